// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store unit master for the single-port word memory.
// Turns byte/half/word requests from the core into one lane-aligned memory
// access, extends load data and returns one response per request.
// Optional build macro LSU_MISALIGN_SPLIT_EN: misaligned accesses run in one
// access when they fit inside a word, otherwise as two (low word, then next).
module lsu_mem_master #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_read_ready,
    output logic [ADDR_W-3:0] mem_read_address,
    input  logic [31:0]       mem_read_data,
    output logic              mem_write_ready,
    output logic [ADDR_W-3:0] mem_write_address,
    output logic [31:0]       mem_write_data,
    output logic [3:0]        mem_write_byte
);

    localparam int WA_W = ADDR_W - 2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DATA,
        RESP
`ifdef LSU_MISALIGN_SPLIT_EN
        ,
        ISSUE_HI,
        DATA_HI
`endif
    } state_t;

    state_t state, state_d;

    // The first access is launched straight from the request inputs at the
    // accept edge, so only the fields needed afterwards are held here.
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  req_off;
    logic        accept;
    logic        accept_err;

    logic            rd_d;
    logic            wr_d;
    logic [WA_W-1:0] maddr_d;
    logic [31:0]     mwdata_d;
    logic [3:0]      mbyte_d;
    logic [31:0]     load_word;
    logic [31:0]     load_ext;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [WA_W-1:0] word_q;
    logic [31:0]     wdata_q;
    logic            split_q;
    logic [31:0]     lo_word_q;
    logic [2:0]      req_bytes;
    logic            req_cross;
    logic [7:0]      hi_mask;

    assign req_bytes  = (req_size == 2'b00) ? 3'd1 : (req_size == 2'b01) ? 3'd2 : 3'd4;
    assign req_cross  = ({1'b0, req_off} + req_bytes) > 3'd4;
    assign accept_err = (req_size == 2'b11);
`else
    assign accept_err = (req_size == 2'b11)
                      || (req_size == 2'b01 && req_addr[0])
                      || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`endif

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] size,
                                           input logic uns);
        case (size)
            2'b00:   return uns ? {24'd0, d[7:0]} : {{24{d[7]}}, d[7:0]};
            2'b01:   return uns ? {16'd0, d[15:0]} : {{16{d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    // req_ready is forced low while reset is held so every output reads 0.
    assign req_ready = (state == IDLE) && resetn;
    assign rsp_valid = (state == RESP);
    assign req_off   = req_addr[1:0];
    assign accept    = req_valid && req_ready;

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_d;
    end

    // Next-state logic: one outstanding access, response held until taken.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:  if (accept) state_d = accept_err ? RESP : ISSUE;
`ifdef LSU_MISALIGN_SPLIT_EN
            ISSUE: state_d = we_q ? (split_q ? ISSUE_HI : RESP) : DATA;
            DATA:  state_d = split_q ? ISSUE_HI : RESP;
            ISSUE_HI: state_d = we_q ? RESP : DATA_HI;
            DATA_HI:  state_d = RESP;
`else
            ISSUE: state_d = we_q ? RESP : DATA;
            DATA:  state_d = RESP;
`endif
            RESP:  if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory-side values for the next cycle; zero whenever no strobe is due.
    always_comb begin
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        maddr_d  = '0;
        mwdata_d = '0;
        mbyte_d  = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
        hi_mask  = '0;
`endif
        if (accept && !accept_err) begin
            rd_d    = !req_we;
            wr_d    = req_we;
            maddr_d = req_addr[ADDR_W-1:2];
            if (req_we) begin
                mbyte_d  = size_mask(req_size) << req_off;
                mwdata_d = req_wdata << {req_off, 3'b000};
            end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        else if (state_d == ISSUE_HI) begin
            rd_d    = !we_q;
            wr_d    = we_q;
            maddr_d = word_q + WA_W'(1);
            if (we_q) begin
                hi_mask  = {4'b0000, size_mask(size_q)} << off_q;
                mbyte_d  = hi_mask[7:4];
                mwdata_d = wdata_q >> {3'd4 - {1'b0, off_q}, 3'b000};
            end
        end
`endif
    end

    // Registered memory outputs, so each strobe lasts exactly one cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_read_ready    <= 1'b0;
            mem_write_ready   <= 1'b0;
            mem_read_address  <= '0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            mem_write_byte    <= '0;
        end else begin
            mem_read_ready    <= rd_d;
            mem_write_ready   <= wr_d;
            mem_read_address  <= rd_d ? maddr_d : '0;
            mem_write_address <= wr_d ? maddr_d : '0;
            mem_write_data    <= mwdata_d;
            mem_write_byte    <= mbyte_d;
        end
    end

    // Capture the request fields that later states still need.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            off_q   <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            word_q  <= '0;
            wdata_q <= '0;
            split_q <= 1'b0;
`endif
        end else if (accept) begin
            off_q   <= req_off;
            size_q  <= req_size;
            we_q    <= req_we;
            uns_q   <= req_unsigned;
`ifdef LSU_MISALIGN_SPLIT_EN
            word_q  <= req_addr[ADDR_W-1:2];
            wdata_q <= req_wdata;
            split_q <= req_cross;
`endif
        end
    end

    // Pick the addressed bytes out of the returned word(s), then extend.
    always_comb begin
        load_word = mem_read_data >> {off_q, 3'b000};
`ifdef LSU_MISALIGN_SPLIT_EN
        if (state == DATA_HI) load_word = 32'({mem_read_data, lo_word_q} >> {off_q, 3'b000});
`endif
        load_ext = extend(load_word, size_q, uns_q);
    end

    // Response registers: error flag set at accept, data loaded from memory.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            lo_word_q <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    rsp_rdata <= '0;
                    rsp_err   <= accept_err;
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                DATA: begin
                    lo_word_q <= mem_read_data;
                    if (!split_q) rsp_rdata <= load_ext;
                end
                DATA_HI: rsp_rdata <= load_ext;
`else
                DATA: rsp_rdata <= load_ext;
`endif
                RESP: if (rsp_ready) begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed vectors against a small word memory model.
// Expected values are hand-computed from the preloaded memory contents.
`timescale 1ns/1ps
module tb_lsu_mem_master;

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_read_ready;
    logic [29:0] mem_read_address;
    logic [31:0] mem_read_data;
    logic        mem_write_ready;
    logic [29:0] mem_write_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_byte;

    logic        mem_init;
    logic [31:0] mem [0:255];

    int vectors     = 0;
    int miscompares = 0;
    int latency     = 0;
    int rd_total    = 0;
    int wr_total    = 0;
    int rd_mark     = 0;
    int wr_mark     = 0;
    logic [29:0] rd_log    [0:15];
    logic [29:0] wr_log    [0:15];
    logic [3:0]  wr_mask_log [0:15];
    logic [31:0] wr_data_log [0:15];

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [29:0] exp_maddr;
        logic [3:0]  exp_mask;
        logic [31:0] exp_mdata;
    } vec_t;

    vec_t phase_a[$];
    vec_t phase_b[$];

    lsu_mem_master #(.ADDR_W(32)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_we            (req_we),
        .req_addr          (req_addr),
        .req_size          (req_size),
        .req_unsigned      (req_unsigned),
        .req_wdata         (req_wdata),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_rdata         (rsp_rdata),
        .rsp_err           (rsp_err),
        .mem_read_ready    (mem_read_ready),
        .mem_read_address  (mem_read_address),
        .mem_read_data     (mem_read_data),
        .mem_write_ready   (mem_write_ready),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_write_byte    (mem_write_byte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory with one-cycle registered read data and byte-lane writes.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h40] <= 32'h887766F5;
            mem[8'h41] <= 32'h00000011;
        end else begin
            if (mem_read_ready) mem_read_data <= mem[mem_read_address[7:0]];
            if (mem_write_ready)
                for (int b = 0; b < 4; b++)
                    if (mem_write_byte[b])
                        mem[mem_write_address[7:0]][8*b +: 8] <= mem_write_data[8*b +: 8];
        end
    end

    // Strobe monitor: logs every memory access away from the clock edge.
    always @(negedge clk) begin
        if (mem_read_ready) begin
            rd_log[rd_total % 16] = mem_read_address;
            rd_total++;
        end
        if (mem_write_ready) begin
            wr_log[wr_total % 16]      = mem_write_address;
            wr_mask_log[wr_total % 16] = mem_write_byte;
            wr_data_log[wr_total % 16] = mem_write_data;
            wr_total++;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish within 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic vec_t mkVec(input string name, input logic we, input logic [31:0] addr,
                                   input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                                   input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                                   input int exp_rd, input int exp_wr, input logic [29:0] exp_maddr,
                                   input logic [3:0] exp_mask, input logic [31:0] exp_mdata);
        vec_t v;
        v.name = name; v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.exp_maddr = exp_maddr;
        v.exp_mask = exp_mask; v.exp_mdata = exp_mdata;
        return v;
    endfunction

    // Present one request, let it be accepted, then wait (bounded) for rsp_valid.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] wdata);
        int waited;
        bit got;
        @(negedge clk);
        rd_mark      = rd_total;
        wr_mark      = wr_total;
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        waited = 0;
        got = 0;
        while (!got && waited < 20) begin
            @(negedge clk);
            waited++;
            if (rsp_valid) got = 1;
        end
        latency = got ? waited : -1;
    endtask

    task automatic finishResponse(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checkOutput({tag, "_release"}, 64'({rsp_valid, rsp_err, req_ready, rsp_rdata}),
                    64'({1'b0, 1'b0, 1'b1, 32'h0}));
    endtask

    task automatic runVector(input vec_t v);
        applyStimulus(v.we, v.addr, v.size, v.uns, v.wdata);
        checkOutput({v.name, "_lat"}, 64'(latency), 64'(v.exp_lat));
        checkOutput({v.name, "_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
        checkOutput({v.name, "_err"}, 64'(rsp_err), 64'(v.exp_err));
        checkOutput({v.name, "_rd_cnt"}, 64'(rd_total - rd_mark), 64'(v.exp_rd));
        checkOutput({v.name, "_wr_cnt"}, 64'(wr_total - wr_mark), 64'(v.exp_wr));
        if (v.exp_rd > 0)
            checkOutput({v.name, "_rd_addr"}, 64'(rd_log[rd_mark % 16]), 64'(v.exp_maddr));
        if (v.exp_rd > 1)
            checkOutput({v.name, "_rd_addr_hi"}, 64'(rd_log[(rd_mark + 1) % 16]),
                        64'(v.exp_maddr + 30'd1));
        if (v.exp_wr > 0) begin
            checkOutput({v.name, "_wr_addr"}, 64'(wr_log[wr_mark % 16]), 64'(v.exp_maddr));
            checkOutput({v.name, "_wr_mask"}, 64'(wr_mask_log[wr_mark % 16]), 64'(v.exp_mask));
            checkOutput({v.name, "_wr_data"}, 64'(wr_data_log[wr_mark % 16]), 64'(v.exp_mdata));
        end
        finishResponse(v.name);
    endtask

    // LH response held unaccepted for 5 cycles while another request waits.
    task automatic holdResponse();
        int hold_rd;
        int hold_wr;
        applyStimulus(1'b0, 32'h100, 2'b01, 1'b0, 32'h0);
        checkOutput("hold_lat", 64'(latency), 64'd3);
        hold_rd      = rd_total;
        hold_wr      = wr_total;
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_addr     = 32'h200;
        req_size     = 2'b10;
        req_wdata    = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("hold_cycle%0d", i),
                        64'({rsp_valid, req_ready, rsp_err, rsp_rdata}),
                        64'({1'b1, 1'b0, 1'b0, 32'h000066F5}));
        end
        req_valid = 1'b0;
        checkOutput("hold_no_strobe", 64'((rd_total - hold_rd) + (wr_total - hold_wr)), 64'd0);
        finishResponse("hold");
    endtask

    // Start an LW, assert reset in ISSUE (extra=0) or DATA (extra=1).
    task automatic resetMidAccess(input string tag, input int extra);
        int seen;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_addr     = 32'h100;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (extra == 0) begin
            checkOutput({tag, "_strobe_before"}, 64'({mem_read_ready, mem_read_address}),
                        64'({1'b1, 30'h040}));
        end else begin
            @(posedge clk);
            #1;
        end
        resetn = 1'b0;
        #1;
        checkOutput({tag, "_ctl_zero"},
                    64'({rsp_valid, req_ready, rsp_err, mem_read_ready, mem_write_ready,
                         mem_write_byte, rsp_rdata}), 64'd0);
        checkOutput({tag, "_addr_zero"}, 64'({mem_read_address, mem_write_address}), 64'd0);
        checkOutput({tag, "_wdata_zero"}, 64'(mem_write_data), 64'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        checkOutput({tag, "_no_rsp"}, 64'(seen), 64'd0);
        checkOutput({tag, "_ready_after"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        resetn       = 1'b0;
        mem_init     = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_size     = '0;
        req_unsigned = 1'b0;
        req_wdata    = '0;
        rsp_ready    = 1'b0;

        phase_a.push_back(mkVec("lb_100",  0, 32'h100, 2'b00, 0, 0, 32'hFFFFFFF5, 0, 3, 1, 0, 30'h040, 0, 0));
        phase_a.push_back(mkVec("lbu_100", 0, 32'h100, 2'b00, 1, 0, 32'h000000F5, 0, 3, 1, 0, 30'h040, 0, 0));
        phase_a.push_back(mkVec("sh_102",  1, 32'h102, 2'b01, 0, 32'h0000BEEF, 32'h0, 0, 2, 0, 1, 30'h040, 4'b1100, 32'hBEEF0000));
        phase_a.push_back(mkVec("lw_100",  0, 32'h100, 2'b10, 0, 0, 32'hBEEF66F5, 0, 3, 1, 0, 30'h040, 0, 0));
        phase_a.push_back(mkVec("lh_102",  0, 32'h102, 2'b01, 0, 0, 32'hFFFFBEEF, 0, 3, 1, 0, 30'h040, 0, 0));
        phase_a.push_back(mkVec("lhu_102", 0, 32'h102, 2'b01, 1, 0, 32'h0000BEEF, 0, 3, 1, 0, 30'h040, 0, 0));
        phase_a.push_back(mkVec("lb_101",  0, 32'h101, 2'b00, 0, 0, 32'h00000066, 0, 3, 1, 0, 30'h040, 0, 0));
        phase_a.push_back(mkVec("lb_103",  0, 32'h103, 2'b00, 0, 0, 32'hFFFFFFBE, 0, 3, 1, 0, 30'h040, 0, 0));
`ifdef LSU_MISALIGN_SPLIT_EN
        phase_a.push_back(mkVec("lw_101",  0, 32'h101, 2'b10, 0, 0, 32'h11BEEF66, 0, 5, 2, 0, 30'h040, 0, 0));
`else
        phase_a.push_back(mkVec("lw_101",  0, 32'h101, 2'b10, 0, 0, 32'h0, 1, 1, 0, 0, 30'h0, 0, 0));
`endif

        phase_b.push_back(mkVec("sb_103",  1, 32'h103, 2'b00, 0, 32'h000000AA, 32'h0, 0, 2, 0, 1, 30'h040, 4'b1000, 32'hAA000000));
        phase_b.push_back(mkVec("st_rsvd", 1, 32'h100, 2'b11, 0, 32'h12345678, 32'h0, 1, 1, 0, 0, 30'h0, 0, 0));
        phase_b.push_back(mkVec("lw_100b", 0, 32'h100, 2'b10, 0, 0, 32'hAAEF66F5, 0, 3, 1, 0, 30'h040, 0, 0));
        phase_b.push_back(mkVec("sw_104",  1, 32'h104, 2'b10, 0, 32'hCAFEBABE, 32'h0, 0, 2, 0, 1, 30'h041, 4'b1111, 32'hCAFEBABE));
        phase_b.push_back(mkVec("lhu_106", 0, 32'h106, 2'b01, 1, 0, 32'h0000CAFE, 0, 3, 1, 0, 30'h041, 0, 0));
        phase_b.push_back(mkVec("lb_104",  0, 32'h104, 2'b00, 0, 0, 32'hFFFFFFBE, 0, 3, 1, 0, 30'h041, 0, 0));
        phase_b.push_back(mkVec("ld_rsvd", 0, 32'h100, 2'b11, 0, 0, 32'h0, 1, 1, 0, 0, 30'h0, 0, 0));
`ifdef LSU_MISALIGN_SPLIT_EN
        phase_b.push_back(mkVec("sh_101",  1, 32'h101, 2'b01, 0, 32'h00001234, 32'h0, 0, 2, 0, 1, 30'h040, 4'b0110, 32'h00123400));
`else
        phase_b.push_back(mkVec("sh_101",  1, 32'h101, 2'b01, 0, 32'h00001234, 32'h0, 1, 1, 0, 0, 30'h0, 0, 0));
`endif

        repeat (3) @(negedge clk);
        checkOutput("reset_ctl_zero",
                    64'({rsp_valid, req_ready, rsp_err, mem_read_ready, mem_write_ready,
                         mem_write_byte, rsp_rdata}), 64'd0);
        resetn   = 1'b1;
        mem_init = 1'b0;
        @(negedge clk);
        checkOutput("reset_req_ready", 64'({req_ready, rsp_valid}), 64'({1'b1, 1'b0}));

        foreach (phase_a[i]) runVector(phase_a[i]);
        holdResponse();
        resetMidAccess("rst_issue", 0);
        resetMidAccess("rst_data", 1);
        foreach (phase_b[i]) runVector(phase_b[i]);
        checkOutput("mem_word41", 64'(mem[8'h41]), 64'h00000000CAFEBABE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
